// File: rtl/vector_checker.sv
// vector_checker: consumer end of the cycler test-vector stream.
// Aligns expected fields to DUT latency, compares, counts, latches first failure.
module vector_checker #(
    parameter int LATENCY    = 2,
    parameter int NUM_CHECKS = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       vector,
    input  logic [4:0]       dut_out,
    input  logic [4:0]       cmp_mask,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] check_count,
    output logic [CNT_W-1:0] err_count,
    output logic [7:0]       first_fail_vec,
    output logic [4:0]       first_fail_got
);
    typedef enum logic [1:0] {IDLE, FILL, CHECK, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(NUM_CHECKS - 1);
    localparam logic [3:0]       FILL_TOP = 4'(LATENCY - 1);

    state_t           state;
    logic [7:0]       dline [LATENCY];
    logic [7:0]       exp_vec;
    logic [4:0]       mask_q;
    logic [3:0]       fill_cnt;
    logic             mismatch;
    logic             err_sat;
    logic [CNT_W-1:0] err_next;

    assign exp_vec  = dline[LATENCY-1];
    assign mismatch = |((exp_vec[4:0] ^ dut_out) & mask_q);
    assign err_sat  = &err_count;
    assign err_next = (mismatch && !err_sat) ? err_count + 1'b1 : err_count;

    // Delay line runs in every state so it is already primed when a run starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) dline[i] <= '0;
        end else begin
            dline[0] <= vector;
            for (int i = 1; i < LATENCY; i++) dline[i] <= dline[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fill_cnt       <= '0;
            mask_q         <= '0;
            check_count    <= '0;
            err_count      <= '0;
            first_fail_vec <= '0;
            first_fail_got <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= FILL;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        fill_cnt       <= FILL_TOP;
                        mask_q         <= cmp_mask;
                        check_count    <= '0;
                        err_count      <= '0;
                        first_fail_vec <= '0;
                        first_fail_got <= '0;
                    end
                end
                FILL: begin
                    if (fill_cnt == 4'd0) state <= CHECK;
                    else fill_cnt <= fill_cnt - 1'b1;
                end
                CHECK: begin
                    check_count <= check_count + 1'b1;
                    err_count   <= err_next;
                    // err_count saturates above zero, so zero means no failure yet
                    if (mismatch && err_count == '0) begin
                        first_fail_vec <= exp_vec;
                        first_fail_got <= dut_out;
                    end
                    if (check_count == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_checker.sv
// tb_vector_checker: drives cycler-like and random streams into vector_checker,
// checks every cycle against a cycle-history reference model.
module tb_vector_checker;
    localparam int L  = 2;
    localparam int N  = 64;
    localparam int W  = 16;
    localparam int NC = 8192;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [7:0]   vector;
    logic [4:0]   dut_out, cmp_mask;
    logic         busy, done, pass;
    logic [W-1:0] check_count, err_count;
    logic [7:0]   first_fail_vec;
    logic [4:0]   first_fail_got;

    int total = 0;
    int bad   = 0;

    vector_checker #(.LATENCY(L), .NUM_CHECKS(N), .CNT_W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .vector(vector),
        .dut_out(dut_out), .cmp_mask(cmp_mask), .busy(busy), .done(done),
        .pass(pass), .check_count(check_count), .err_count(err_count),
        .first_fail_vec(first_fail_vec), .first_fail_got(first_fail_got)
    );

    always #5 clk = ~clk;

    // Reference ALU/bit-slice: {A,B,X} -> {c1/OR, s1/EQ, s0/XOR, c0/AND, LT}
    function automatic logic [4:0] golden(input logic [2:0] st);
        logic a, b, x;
        a = st[2]; b = st[1]; x = st[0];
        if (!x) return {a | b, ~(a ^ b), a ^ b, a & b, ~a & b};
        return {a & b, 1'b0, a ^ b, a | b, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Stimulus generator and modelled DUT
    int         pidx  = 0;
    int         dlat  = 2;
    int         fault = 0;
    bit         rnd   = 0;
    logic [7:0] hist[$];

    task automatic tick();
        logic [7:0] v, old;
        logic [4:0] d;
        logic [2:0] st;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        if (rnd) v = 8'($urandom);
        else begin
            st = 3'(pidx);
            v  = {st, golden(st)};
        end
        pidx++;
        hist.push_front(v);
        if (hist.size() > 12) void'(hist.pop_back());
        d = 5'd0;
        if (hist.size() > dlat) begin
            old = hist[dlat];
            d   = golden(old[7:5]);
        end
        case (fault)
            1: d[3] = 1'b0;
            2: if ($urandom_range(0, 3) == 0) d = d ^ 5'($urandom);
            3: d = ~d;
            default: ;
        endcase
        vector  = v;
        dut_out = d;
    endtask

    task automatic do_start(input logic [4:0] m);
        tick();
        start    = 1'b1;
        cmp_mask = m;
        pidx     = 0;
    endtask

    task automatic run_done(output int n);
        tick();
        n = 1;
        while (!done && n < 300) begin
            tick();
            n++;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL run_timeout: done=%0b after %0d cycles want 1", done, n);
        end
    endtask

    // Reference model: rebuilds outputs from recorded per-cycle inputs
    logic [7:0]   vh [NC];
    logic [4:0]   dh [NC];
    int           cyc = 0;
    bit           run = 0;
    int           s   = 0;
    logic [4:0]   mq  = '0;
    bit           mon = 0;
    logic         e_busy = 0, e_done = 0, e_pass = 0;
    logic [W-1:0] e_chk = '0, e_err = '0;
    logic [7:0]   e_ffv = '0;
    logic [4:0]   e_ffg = '0;
    int           mk, mnc, mne;
    logic [7:0]   mv;
    logic [4:0]   md;

    initial forever begin
        @(posedge clk);
        if (cyc >= NC - 1) begin
            $display("FAIL model_overflow: cycles %0d limit %0d", cyc, NC);
            $fatal(1);
        end
        vh[cyc] = vector;
        dh[cyc] = dut_out;
        if (reset) run = 0;
        else if (start && (!run || cyc - s >= L + N + 1)) begin
            run = 1;
            s   = cyc;
            mq  = cmp_mask;
        end
        e_busy = 0; e_done = 0; e_pass = 0;
        e_chk = '0; e_err = '0; e_ffv = '0; e_ffg = '0;
        if (run) begin
            mk  = cyc + 1 - s;
            e_busy = (mk >= 1 && mk <= L + N);
            e_done = (mk >= L + N + 1);
            mnc = mk - L - 1;
            if (mnc < 0) mnc = 0;
            if (mnc > N) mnc = N;
            mne = 0;
            for (int j = 0; j < mnc; j++) begin
                mv = vh[s + 1 + j];
                md = dh[s + L + 1 + j];
                if (((mv[4:0] ^ md) & mq) != 5'd0) begin
                    if (mne == 0) begin
                        e_ffv = mv;
                        e_ffg = md;
                    end
                    mne++;
                end
            end
            e_chk  = W'(mnc);
            e_err  = W'(mne);
            e_pass = e_done && (mne == 0);
        end
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (mon) begin
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("pass", pass, e_pass);
            chk("check_count", check_count, e_chk);
            chk("err_count", err_count, e_err);
            chk("first_fail_vec", first_fail_vec, e_ffv);
            chk("first_fail_got", first_fail_got, e_ffg);
        end
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0;
        vector = '0; dut_out = '0; cmp_mask = '0;
        repeat (2) @(posedge clk);
        #1;
        mon = 1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", check_count, 0);

        // exact DUT, full mask
        do_start(5'h1F);
        run_done(n);
        chk("t1_latency", n, 67);
        chk("t1_count", check_count, 64);
        chk("t1_err", err_count, 0);
        chk("t1_pass", pass, 1);
        chk("t1_ffv", first_fail_vec, 0);

        // EQ stuck at 0
        fault = 1;
        do_start(5'h1F);
        run_done(n);
        chk("t2_err", err_count, 16);
        chk("t2_pass", pass, 0);
        chk("t2_ffv", first_fail_vec, 8'h08);
        chk("t2_ffg", first_fail_got, 5'h00);

        // same fault, EQ masked off
        do_start(5'h17);
        run_done(n);
        chk("t3_err", err_count, 0);
        chk("t3_pass", pass, 1);

        // DUT one cycle slower than the checker expects
        fault = 0;
        dlat  = 3;
        do_start(5'h1F);
        run_done(n);
        chk("t4_err_nonzero", err_count != 0, 1);
        chk("t4_pass", pass, 0);
        dlat = 2;

        // reset mid-run
        do_start(5'h1F);
        n = 0;
        while (check_count != 10 && n < 100) begin
            tick();
            n++;
        end
        chk("t5_reach10", check_count, 10);
        tick();
        reset = 1'b1;
        tick();
        chk("t5_busy", busy, 0);
        chk("t5_count", check_count, 0);
        chk("t5_err", err_count, 0);
        chk("t5_done", done, 0);
        do_start(5'h1F);
        run_done(n);
        chk("t5_rerun_count", check_count, 64);
        chk("t5_rerun_pass", pass, 1);

        // always-wrong DUT, start during CHECK ignored
        fault = 3;
        do_start(5'h1F);
        repeat (20) tick();
        start    = 1'b1;
        cmp_mask = 5'h00;
        run_done(n);
        chk("t6_latency", n + 20, 67);
        chk("t6_err", err_count, 64);
        chk("t6_pass", pass, 0);
        chk("t6_ffv", first_fail_vec, 8'h08);
        chk("t6_ffg", first_fail_got, 5'h17);

        // start from DONE clears counters; zero mask passes everything
        do_start(5'h00);
        tick();
        chk("t6_clr_count", check_count, 0);
        chk("t6_clr_err", err_count, 0);
        chk("t6_clr_busy", busy, 1);
        chk("t6_clr_done", done, 0);
        run_done(n);
        chk("t6_mask0_count", check_count, 64);
        chk("t6_mask0_pass", pass, 1);

        // randomized streams, faults, latencies, starts and resets
        for (int r = 0; r < 12; r++) begin
            rnd   = ($urandom_range(0, 1) == 1);
            fault = ($urandom_range(0, 1) == 1) ? 2 : 0;
            dlat  = $urandom_range(1, 4);
            do_start(5'($urandom));
            repeat ($urandom_range(30, 90)) begin
                tick();
                if ($urandom_range(0, 19) == 0) begin
                    start    = 1'b1;
                    cmp_mask = 5'($urandom);
                end
                if ($urandom_range(0, 199) == 0) reset = 1'b1;
            end
        end
        rnd = 0; fault = 0; dlat = 2;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
